// File: rtl/game_pkg.sv
// Shared constants for the Memory Game controller: card-state codes and FSM state encoding.
package game_pkg;

  localparam int CARD_STATE_W = 2;

  localparam logic [CARD_STATE_W-1:0] HIDDEN  = 2'b00;
  localparam logic [CARD_STATE_W-1:0] SHOWN   = 2'b01;
  localparam logic [CARD_STATE_W-1:0] MATCHED = 2'b10;

  localparam int STATE_W = 5;

  localparam logic [STATE_W-1:0] S_IDLE    = 5'd0;
  localparam logic [STATE_W-1:0] S_COMPUTE = 5'd1;
  localparam logic [STATE_W-1:0] S_REFRESH = 5'd2;
  localparam logic [STATE_W-1:0] S_WAIT1   = 5'd3;
  localparam logic [STATE_W-1:0] S_FETCH1  = 5'd4;
  localparam logic [STATE_W-1:0] S_SHOW1   = 5'd5;
  localparam logic [STATE_W-1:0] S_WAIT2   = 5'd6;
  localparam logic [STATE_W-1:0] S_FETCH2  = 5'd7;
  localparam logic [STATE_W-1:0] S_SHOW2   = 5'd8;
  localparam logic [STATE_W-1:0] S_COMPARE = 5'd9;
  localparam logic [STATE_W-1:0] S_HOLD    = 5'd10;
  localparam logic [STATE_W-1:0] S_HIDE_A  = 5'd11;
  localparam logic [STATE_W-1:0] S_HIDE_B  = 5'd12;
  localparam logic [STATE_W-1:0] S_MATCH_A = 5'd13;
  localparam logic [STATE_W-1:0] S_MATCH_B = 5'd14;
  localparam logic [STATE_W-1:0] S_NEXT    = 5'd15;
  localparam logic [STATE_W-1:0] S_END     = 5'd16;

endpackage

// File: rtl/game_ctl_reveal_timer.sv
// One-shot delay: `done` pulses exactly CYCLES cycles after the cycle in which `start` is high.
module reveal_timer #(
  parameter int CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  localparam int CW = $clog2(CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Countdown; done is registered so it lands on the CYCLES-th cycle after start.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      cnt_d  = CW'(CYCLES - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        cnt_d  = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= {CW{1'b0}};
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: rtl/game_ctl.sv
// Memory Game round sequencer with card count, turn rotation and timed mismatch reveal.
// Define GAME_CTL_MULTIPLAYER_EN for N-player rotation; otherwise a single player is assumed.
module game_ctl
  import game_pkg::*;
#(
  parameter int N_CARDS       = 16,
  parameter int N_PLAYERS     = 2,
  parameter int COLOR_W       = 12,
  parameter int REVEAL_CYCLES = 65_000_000,
  localparam int AW = $clog2(N_CARDS),
  localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1,
  localparam int SW = $clog2(N_CARDS / 2 + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_pressed,
  input  logic                    restart,
  input  logic                    compute_done,
  input  logic                    card_pressed,
  input  logic [AW-1:0]           card_addr,
  input  logic [COLOR_W-1:0]      card_color,
  output logic                    start_butt_en,
  output logic                    compute_colors_en,
  output logic                    wait_for_click_en,
  output logic                    end_screen_en,
  output logic                    update_cards_en,
  output logic                    write_card_en,
  output logic [AW-1:0]           write_card_addr,
  output logic [1:0]              write_card_state,
  output logic                    stopwatch_en,
  output logic                    stopwatch_disable,
  output logic [PW-1:0]           active_player,
  output logic [N_PLAYERS*SW-1:0] scores,
  output logic [SW-1:0]           pairs_left
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [AW-1:0]      card_a_q, card_a_d, card_b_q, card_b_d;
  logic [COLOR_W-1:0] col_a_q, col_a_d, col_b_q, col_b_d;
  logic [SW-1:0]      pairs_left_q, pairs_left_d;
  logic               score_clr_s, score_inc_s;
  logic               timer_start_s, timer_done_s;

  logic start_butt_en_q, start_butt_en_d;
  logic compute_colors_en_q, compute_colors_en_d;
  logic wait_for_click_en_q, wait_for_click_en_d;
  logic end_screen_en_q, end_screen_en_d;
  logic update_cards_en_q, update_cards_en_d;
  logic write_card_en_q, write_card_en_d;
  logic [AW-1:0] write_card_addr_q, write_card_addr_d;
  logic [CARD_STATE_W-1:0] write_card_state_q, write_card_state_d;
  logic stopwatch_en_q, stopwatch_en_d;
  logic stopwatch_disable_q, stopwatch_disable_d;

  reveal_timer #(.CYCLES(REVEAL_CYCLES)) u_reveal_timer (
    .clk   (clk),
    .rst   (rst),
    .start (timer_start_s),
    .done  (timer_done_s)
  );

  // Round sequencing; inputs outside their listed states are simply not looked at.
  always_comb begin
    state_d       = state_q;
    card_a_d      = card_a_q;
    card_b_d      = card_b_q;
    col_a_d       = col_a_q;
    col_b_d       = col_b_q;
    pairs_left_d  = pairs_left_q;
    score_clr_s   = 1'b0;
    score_inc_s   = 1'b0;
    timer_start_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_pressed) begin
          state_d      = S_COMPUTE;
          score_clr_s  = 1'b1;
          pairs_left_d = SW'(N_CARDS / 2);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMPUTE: begin
        if (compute_done) state_d = S_REFRESH;
        else              state_d = S_COMPUTE;
      end
      S_REFRESH: state_d = S_WAIT1;
      S_WAIT1: begin
        if (card_pressed) begin
          card_a_d = card_addr;
          state_d  = S_FETCH1;
        end else begin
          state_d = S_WAIT1;
        end
      end
      S_FETCH1: begin
        col_a_d = card_color;
        state_d = S_SHOW1;
      end
      S_SHOW1: state_d = S_WAIT2;
      S_WAIT2: begin
        // Re-clicking the first card cannot form a pair.
        if (card_pressed && (card_addr != card_a_q)) begin
          card_b_d = card_addr;
          state_d  = S_FETCH2;
        end else begin
          state_d = S_WAIT2;
        end
      end
      S_FETCH2: begin
        col_b_d = card_color;
        state_d = S_SHOW2;
      end
      S_SHOW2: state_d = S_COMPARE;
      S_COMPARE: begin
        if (col_a_q == col_b_q) begin
          state_d = S_MATCH_A;
        end else begin
          state_d       = S_HOLD;
          timer_start_s = 1'b1;
        end
      end
      S_HOLD: begin
        if (timer_done_s) state_d = S_HIDE_A;
        else              state_d = S_HOLD;
      end
      S_HIDE_A:  state_d = S_HIDE_B;
      S_HIDE_B:  state_d = S_NEXT;
      S_MATCH_A: state_d = S_MATCH_B;
      S_MATCH_B: begin
        score_inc_s  = 1'b1;
        pairs_left_d = pairs_left_q - SW'(1);
        state_d      = S_NEXT;
      end
      S_NEXT: begin
        if (pairs_left_q == {SW{1'b0}}) state_d = S_END;
        else                            state_d = S_WAIT1;
      end
      S_END: begin
        if (restart) begin
          state_d     = S_IDLE;
          score_clr_s = 1'b1;
        end else begin
          state_d = S_END;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each one is a flop aligned with its state.
  always_comb begin
    start_butt_en_d     = (state_d == S_IDLE);
    compute_colors_en_d = (state_d == S_COMPUTE);
    wait_for_click_en_d = (state_d == S_WAIT1) || (state_d == S_WAIT2);
    end_screen_en_d     = (state_d == S_END);
    update_cards_en_d   = (state_d == S_REFRESH) || (state_d == S_NEXT) ||
                          (state_q == S_SHOW1) || (state_q == S_SHOW2);
    stopwatch_en_d      = (state_q == S_COMPUTE) && (state_d == S_REFRESH);
    stopwatch_disable_d = (state_q == S_NEXT) && (state_d == S_END);
    write_card_en_d     = 1'b1;
    write_card_addr_d   = card_a_q;
    write_card_state_d  = HIDDEN;
    case (state_d)
      S_SHOW1:   write_card_state_d = SHOWN;
      S_SHOW2: begin
        write_card_addr_d  = card_b_q;
        write_card_state_d = SHOWN;
      end
      S_MATCH_A: write_card_state_d = MATCHED;
      S_MATCH_B: begin
        write_card_addr_d  = card_b_q;
        write_card_state_d = MATCHED;
      end
      S_HIDE_A:  write_card_state_d = HIDDEN;
      S_HIDE_B:  write_card_addr_d  = card_b_q;
      default: begin
        write_card_en_d   = 1'b0;
        write_card_addr_d = {AW{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= S_IDLE;
      card_a_q            <= {AW{1'b0}};
      card_b_q            <= {AW{1'b0}};
      col_a_q             <= {COLOR_W{1'b0}};
      col_b_q             <= {COLOR_W{1'b0}};
      pairs_left_q        <= {SW{1'b0}};
      start_butt_en_q     <= 1'b0;
      compute_colors_en_q <= 1'b0;
      wait_for_click_en_q <= 1'b0;
      end_screen_en_q     <= 1'b0;
      update_cards_en_q   <= 1'b0;
      write_card_en_q     <= 1'b0;
      write_card_addr_q   <= {AW{1'b0}};
      write_card_state_q  <= HIDDEN;
      stopwatch_en_q      <= 1'b0;
      stopwatch_disable_q <= 1'b0;
    end else begin
      state_q             <= state_d;
      card_a_q            <= card_a_d;
      card_b_q            <= card_b_d;
      col_a_q             <= col_a_d;
      col_b_q             <= col_b_d;
      pairs_left_q        <= pairs_left_d;
      start_butt_en_q     <= start_butt_en_d;
      compute_colors_en_q <= compute_colors_en_d;
      wait_for_click_en_q <= wait_for_click_en_d;
      end_screen_en_q     <= end_screen_en_d;
      update_cards_en_q   <= update_cards_en_d;
      write_card_en_q     <= write_card_en_d;
      write_card_addr_q   <= write_card_addr_d;
      write_card_state_q  <= write_card_state_d;
      stopwatch_en_q      <= stopwatch_en_d;
      stopwatch_disable_q <= stopwatch_disable_d;
    end
  end

`ifdef GAME_CTL_MULTIPLAYER_EN
  logic [PW-1:0]           active_player_q, active_player_d;
  logic [N_PLAYERS*SW-1:0] scores_q, scores_d;
  logic                    player_adv_s;

  assign player_adv_s = (state_q == S_HIDE_B);

  // A match keeps the turn; a mismatch hands it to the next player.
  always_comb begin
    active_player_d = active_player_q;
    scores_d        = scores_q;
    if (score_clr_s) begin
      active_player_d = {PW{1'b0}};
      scores_d        = {(N_PLAYERS*SW){1'b0}};
    end else if (score_inc_s) begin
      scores_d[active_player_q*SW +: SW] = scores_q[active_player_q*SW +: SW] + SW'(1);
    end else if (player_adv_s) begin
      if (active_player_q == PW'(N_PLAYERS - 1)) active_player_d = {PW{1'b0}};
      else                                       active_player_d = active_player_q + PW'(1);
    end else begin
      active_player_d = active_player_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_player_q <= {PW{1'b0}};
      scores_q        <= {(N_PLAYERS*SW){1'b0}};
    end else begin
      active_player_q <= active_player_d;
      scores_q        <= scores_d;
    end
  end

  assign active_player = active_player_q;
  assign scores        = scores_q;
`else
  logic [SW-1:0] score0_q, score0_d;

  // Single-player score: only slot 0 is ever live.
  always_comb begin
    if (score_clr_s)      score0_d = {SW{1'b0}};
    else if (score_inc_s) score0_d = score0_q + SW'(1);
    else                  score0_d = score0_q;
  end

  always_ff @(posedge clk) begin
    if (rst) score0_q <= {SW{1'b0}};
    else     score0_q <= score0_d;
  end

  assign active_player = {PW{1'b0}};
  assign scores        = (N_PLAYERS*SW)'(score0_q);
`endif

  assign start_butt_en     = start_butt_en_q;
  assign compute_colors_en = compute_colors_en_q;
  assign wait_for_click_en = wait_for_click_en_q;
  assign end_screen_en     = end_screen_en_q;
  assign update_cards_en   = update_cards_en_q;
  assign write_card_en     = write_card_en_q;
  assign write_card_addr   = write_card_addr_q;
  assign write_card_state  = write_card_state_q;
  assign stopwatch_en      = stopwatch_en_q;
  assign stopwatch_disable = stopwatch_disable_q;
  assign pairs_left        = pairs_left_q;

endmodule
